// File: rtl/axi_burst_write_master.sv
// AXI4 burst write master: one command in, a single INCR burst out on AW/W/B.
// One outstanding burst; phases run strictly AW -> W beats -> B.
module axi_burst_write_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [31:0]       src_data,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] awaddr,
    output logic [LEN_W-1:0]  awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = LEN_W + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ADDR_W-1:0]  r_awaddr;
    logic [LEN_W-1:0]   r_awlen;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_wlast;
    logic               r_wvalid;
    logic               r_awvalid;
    logic               r_bready;
    logic               r_cmd_ready;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_final_loaded;
    logic               r_done;
    logic               r_err;

    logic [ADDR_W-1:0]  w_awaddr_nxt;
    logic [LEN_W-1:0]   w_awlen_nxt;
    logic [DATA_W-1:0]  w_wdata_nxt;
    logic               w_wlast_nxt;
    logic               w_wvalid_nxt;
    logic               w_awvalid_nxt;
    logic               w_bready_nxt;
    logic               w_cmd_ready_nxt;
    logic [CNT_W-1:0]   w_beat_cnt_nxt;
    logic               w_final_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;

    logic               w_cmd_hs;
    logic               w_src_ready;
    logic               w_src_hs;
    logic               w_w_hs;
    logic               w_is_last;

    // Handshakes; the W register accepts a new beat when empty or draining this cycle.
    assign w_cmd_hs    = (r_state == S_IDLE) && cmd_valid && r_cmd_ready;
    assign w_src_ready = (r_state == S_DATA) && (!r_wvalid || wready) && !r_final_loaded;
    assign w_src_hs    = src_valid && w_src_ready;
    assign w_w_hs      = r_wvalid && wready;
    // beat_cnt counts beats loaded into the W register, so it indexes the incoming beat.
    assign w_is_last   = (r_beat_cnt == CNT_W'(r_awlen));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_awaddr_nxt   = r_awaddr;
        w_awlen_nxt    = r_awlen;
        w_wdata_nxt    = r_wdata;
        w_wlast_nxt    = r_wlast;
        w_wvalid_nxt   = r_wvalid;
        w_beat_cnt_nxt = r_beat_cnt;
        w_final_nxt    = r_final_loaded;
        w_err_nxt      = r_err;
        w_done_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_cmd_hs) begin
                    w_awaddr_nxt   = cmd_addr & ALIGN_MASK;
                    w_awlen_nxt    = cmd_len;
                    w_err_nxt      = 1'b0;
                    w_beat_cnt_nxt = '0;
                    w_final_nxt    = 1'b0;
                    w_state_nxt    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (awready) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_w_hs) begin
                    w_wvalid_nxt = 1'b0;
                    if (r_wlast) begin
                        w_state_nxt = S_RESP;
                    end
                end
                if (w_src_hs) begin
                    w_wdata_nxt    = src_data;
                    w_wlast_nxt    = w_is_last;
                    w_wvalid_nxt   = 1'b1;
                    w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                    w_final_nxt    = w_is_last;
                end
            end
            S_RESP: begin
                if (bvalid) begin
                    w_err_nxt   = (bresp != 2'b00);
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
        w_awvalid_nxt   = (w_state_nxt == S_ADDR);
        w_bready_nxt    = (w_state_nxt == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_awaddr       <= '0;
            r_awlen        <= '0;
            r_wdata        <= '0;
            r_wlast        <= 1'b0;
            r_wvalid       <= 1'b0;
            r_awvalid      <= 1'b0;
            r_bready       <= 1'b0;
            r_cmd_ready    <= 1'b0;
            r_beat_cnt     <= '0;
            r_final_loaded <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_awaddr       <= w_awaddr_nxt;
            r_awlen        <= w_awlen_nxt;
            r_wdata        <= w_wdata_nxt;
            r_wlast        <= w_wlast_nxt;
            r_wvalid       <= w_wvalid_nxt;
            r_awvalid      <= w_awvalid_nxt;
            r_bready       <= w_bready_nxt;
            r_cmd_ready    <= w_cmd_ready_nxt;
            r_beat_cnt     <= w_beat_cnt_nxt;
            r_final_loaded <= w_final_nxt;
            r_done         <= w_done_nxt;
            r_err          <= w_err_nxt;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign src_ready = w_src_ready;
    assign done      = r_done;
    assign err       = r_err;
    assign awaddr    = r_awaddr;
    assign awlen     = r_awlen;
    assign awsize    = 3'd2;
    assign awburst   = 2'b01;
    assign awvalid   = r_awvalid;
    assign wdata     = r_wdata;
    assign wstrb     = 4'hF;
    assign wlast     = r_wlast;
    assign wvalid    = r_wvalid;
    assign bready    = r_bready;

endmodule

// File: tb/tb_axi_burst_write_master.sv
// Directed bench for axi_burst_write_master: slave/source driven per cycle,
// a passive monitor logs AW/W handshakes and stall-stability violations.
module tb_axi_burst_write_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        src_valid;
    logic        src_ready;
    logic [31:0] src_data;
    logic        done;
    logic        err;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    axi_burst_write_master #(.ADDR_W(32), .LEN_W(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .done(done), .err(err),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // Passive monitor
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [31:0] w_data_q[$];
    logic        w_last_q[$];
    int          done_cnt = 0;
    int          viol     = 0;
    logic        p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_wlast = 1'b0;
    logic [31:0] p_awaddr = '0, p_wdata = '0;
    logic [7:0]  p_awlen = '0;

    always @(posedge clk) begin
        if (reset) begin
            if (awvalid && awready) begin
                aw_addr_q.push_back(awaddr);
                aw_len_q.push_back(awlen);
            end
            if (wvalid && wready) begin
                w_data_q.push_back(wdata);
                w_last_q.push_back(wlast);
            end
            if (done) done_cnt <= done_cnt + 1;
            if ((p_awv && !p_awr && (!awvalid || awaddr !== p_awaddr || awlen !== p_awlen)) ||
                (p_wv && !p_wr && (!wvalid || wdata !== p_wdata || wlast !== p_wlast)))
                viol <= viol + 1;
        end
        p_awv    <= reset && awvalid;
        p_awr    <= awready;
        p_wv     <= reset && wvalid;
        p_wr     <= wready;
        p_awaddr <= awaddr;
        p_awlen  <= awlen;
        p_wdata  <= wdata;
        p_wlast  <= wlast;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        src_valid = 1'b0; src_data = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    endtask

    task automatic wait_cmd_accept(input logic [31:0] addr, input logic [7:0] len, output bit ok);
        bit hs;
        hs = 1'b0;
        cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
        for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge clk);
            hs = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        ok = hs;
    endtask

    // Runs one burst as slave + source; gap_mask bit i holds src_valid low one cycle before beat i.
    task automatic drive_burst(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] base,
                               input int aw_stall, input bit w_toggle, input logic [31:0] gap_mask,
                               input logic [1:0] resp, output int first_w, output logic err_k1,
                               output bit timed_out);
        bit          ok;
        int          idx;
        logic [31:0] gdone;
        timed_out = 1'b1;
        first_w   = -1;
        err_k1    = 1'bx;
        idle_inputs();
        wait_cmd_accept(addr, len, ok);
        if (ok) begin
            idx    = 0;
            gdone  = '0;
            err_k1 = err;
            for (int k = 1; k < 400; k++) begin
                if (first_w < 0 && wvalid) first_w = k;
                if (done) begin
                    timed_out = 1'b0;
                    break;
                end
                awready = (k > aw_stall);
                wready  = w_toggle ? k[0] : 1'b1;
                bvalid  = 1'b1;
                bresp   = resp;
                if (idx <= int'(len) && idx < 32 && gap_mask[idx] && !gdone[idx]) begin
                    src_valid  = 1'b0;
                    gdone[idx] = 1'b1;
                end else if (idx <= int'(len)) begin
                    src_valid = 1'b1;
                    src_data  = base + 32'(idx);
                end else begin
                    src_valid = 1'b0;
                end
                @(negedge clk);
                if (src_valid && src_ready) idx++;
                tick();
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (3) tick();
        tests_run++;
        if ({awvalid, wvalid, bready, done, err, cmd_ready, src_ready, wlast} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_ctrl got %b expected 00000000",
                     {awvalid, wvalid, bready, done, err, cmd_ready, src_ready, wlast});
        end
        tests_run++;
        if ({awsize, awburst, wstrb} !== {3'd2, 2'b01, 4'hF}) begin
            tests_failed++;
            $display("FAIL reset_const got %h/%h/%h expected 2/1/f", awsize, awburst, wstrb);
        end
        tests_run++;
        if ({awaddr, awlen, wdata} !== 72'h0) begin
            tests_failed++;
            $display("FAIL reset_data got %h %h %h expected 0", awaddr, awlen, wdata);
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_cmd_ready got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        int a0, w0, d0, v0, fw;
        logic e1;
        bit to;
        a0 = aw_addr_q.size(); w0 = w_data_q.size(); d0 = done_cnt; v0 = viol;
        drive_burst(32'h1003, 8'd3, 32'hD0, 0, 1'b0, 32'h0, 2'b00, fw, e1, to);
        tests_run++;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL basic_timeout got %b expected 0", to); end
        tests_run++;
        if (aw_addr_q.size() - a0 !== 1 || aw_addr_q[a0] !== 32'h1000 || aw_len_q[a0] !== 8'd3) begin
            tests_failed++;
            $display("FAIL basic_aw got n=%0d addr=%h len=%0d expected n=1 addr=00001000 len=3",
                     aw_addr_q.size() - a0, aw_addr_q[a0], aw_len_q[a0]);
        end
        tests_run++;
        if (w_data_q.size() - w0 !== 4) begin
            tests_failed++;
            $display("FAIL basic_beats got %0d expected 4", w_data_q.size() - w0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if ({w_data_q[w0+i], w_last_q[w0+i]} !== {32'hD0 + 32'(i), (i == 3)}) begin
                    tests_failed++;
                    $display("FAIL basic_beat%0d got %h/%b expected %h/%b", i, w_data_q[w0+i],
                             w_last_q[w0+i], 32'hD0 + 32'(i), (i == 3));
                end
            end
        end
        tests_run++;
        if (fw !== 3) begin tests_failed++; $display("FAIL basic_first_w_latency got %0d expected 3", fw); end
        tests_run++;
        if ({err, cmd_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL basic_end_err_cmd_ready got %b expected 01", {err, cmd_ready});
        end
        tick();
        tests_run++;
        if (done_cnt - d0 !== 1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done_once got cnt=%0d done=%b expected cnt=1 done=0", done_cnt - d0, done);
        end
        tests_run++;
        if (viol - v0 !== 0) begin tests_failed++; $display("FAIL basic_stability got %0d expected 0", viol - v0); end
    endtask

    task automatic test_single();
        int w0, d0, fw;
        logic e1;
        bit to;
        w0 = w_data_q.size(); d0 = done_cnt;
        drive_burst(32'h0000_2000, 8'd0, 32'hBEEF_BABA, 0, 1'b0, 32'h0, 2'b00, fw, e1, to);
        tests_run++;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL single_timeout got %b expected 0", to); end
        tests_run++;
        if (w_data_q.size() - w0 !== 1 || w_data_q[w0] !== 32'hBEEF_BABA || w_last_q[w0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_beat got n=%0d %h/%b expected n=1 beefbaba/1",
                     w_data_q.size() - w0, w_data_q[w0], w_last_q[w0]);
        end
        tests_run++;
        if ({awlen, err} !== {8'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_len_err got %0d/%b expected 0/0", awlen, err);
        end
        tick();
        tests_run++;
        if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL single_done got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_stall();
        int a0, w0, v0, fw;
        logic e1;
        bit to;
        a0 = aw_addr_q.size(); w0 = w_data_q.size(); v0 = viol;
        drive_burst(32'h0000_5554, 8'd3, 32'h5000, 5, 1'b1, 32'h0, 2'b00, fw, e1, to);
        tests_run++;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL stall_timeout got %b expected 0", to); end
        tests_run++;
        if (viol - v0 !== 0) begin tests_failed++; $display("FAIL stall_stability got %0d expected 0", viol - v0); end
        tests_run++;
        if (aw_addr_q.size() - a0 !== 1 || aw_addr_q[a0] !== 32'h5554) begin
            tests_failed++;
            $display("FAIL stall_aw got n=%0d addr=%h expected n=1 addr=00005554",
                     aw_addr_q.size() - a0, aw_addr_q[a0]);
        end
        tests_run++;
        if (w_data_q.size() - w0 !== 4) begin
            tests_failed++;
            $display("FAIL stall_beats got %0d expected 4", w_data_q.size() - w0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if ({w_data_q[w0+i], w_last_q[w0+i]} !== {32'h5000 + 32'(i), (i == 3)}) begin
                    tests_failed++;
                    $display("FAIL stall_beat%0d got %h/%b expected %h/%b", i, w_data_q[w0+i],
                             w_last_q[w0+i], 32'h5000 + 32'(i), (i == 3));
                end
            end
        end
        tick();
    endtask

    task automatic test_gaps();
        int w0, v0, d0, fw;
        logic e1;
        bit to;
        w0 = w_data_q.size(); v0 = viol; d0 = done_cnt;
        drive_burst(32'h0000_6000, 8'd7, 32'h6600, 0, 1'b0, 32'h0000_0012, 2'b00, fw, e1, to);
        tests_run++;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL gaps_timeout got %b expected 0", to); end
        tests_run++;
        if (w_data_q.size() - w0 !== 8) begin
            tests_failed++;
            $display("FAIL gaps_beats got %0d expected 8", w_data_q.size() - w0);
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests_run++;
                if ({w_data_q[w0+i], w_last_q[w0+i]} !== {32'h6600 + 32'(i), (i == 7)}) begin
                    tests_failed++;
                    $display("FAIL gaps_beat%0d got %h/%b expected %h/%b", i, w_data_q[w0+i],
                             w_last_q[w0+i], 32'h6600 + 32'(i), (i == 7));
                end
            end
        end
        tests_run++;
        if (viol - v0 !== 0) begin tests_failed++; $display("FAIL gaps_stability got %0d expected 0", viol - v0); end
        tick();
        tests_run++;
        if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL gaps_done got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_err();
        int fw;
        logic e1;
        bit to;
        drive_burst(32'h0000_7000, 8'd1, 32'h7700, 0, 1'b0, 32'h0, 2'b10, fw, e1, to);
        tests_run++;
        if ({to, err} !== 2'b01) begin
            tests_failed++;
            $display("FAIL err_set got to=%b err=%b expected to=0 err=1", to, err);
        end
        repeat (4) tick();
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky got %b expected 1", err); end
        drive_burst(32'h0000_7100, 8'd1, 32'h7800, 0, 1'b0, 32'h0, 2'b00, fw, e1, to);
        tests_run++;
        if (e1 !== 1'b0) begin tests_failed++; $display("FAIL err_clear_on_accept got %b expected 0", e1); end
        tests_run++;
        if ({to, err} !== 2'b00) begin
            tests_failed++;
            $display("FAIL err_ok_burst got to=%b err=%b expected to=0 err=0", to, err);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit   ok;
        bit   reached;
        int   w0, a0, d0, fw;
        logic e1;
        bit   to;
        idle_inputs();
        w0 = w_data_q.size();
        reached = 1'b0;
        wait_cmd_accept(32'h0000_3000, 8'd7, ok);
        awready = 1'b1; wready = 1'b1; src_valid = 1'b1; src_data = 32'h3300;
        for (int k = 0; k < 40 && ok && !reached; k++) begin
            if (w_data_q.size() - w0 >= 2) begin
                reached = 1'b1;
            end else begin
                tick();
                src_data = 32'h3300 + 32'(w_data_q.size() - w0 + 1);
            end
        end
        tests_run++;
        if ({reached, wvalid} !== 2'b11) begin
            tests_failed++;
            $display("FAIL rstmid_in_data got reached=%b wvalid=%b expected 1/1", reached, wvalid);
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if ({awvalid, wvalid, bready, done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rstmid_drop got %b expected 0000", {awvalid, wvalid, bready, done});
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        a0 = aw_addr_q.size(); w0 = w_data_q.size(); d0 = done_cnt;
        drive_burst(32'h0000_4004, 8'd1, 32'h4400, 0, 1'b0, 32'h0, 2'b00, fw, e1, to);
        tests_run++;
        if (to !== 1'b0 || aw_addr_q.size() - a0 !== 1 || aw_addr_q[a0] !== 32'h4004) begin
            tests_failed++;
            $display("FAIL rstmid_new_aw got to=%b n=%0d addr=%h expected to=0 n=1 addr=00004004",
                     to, aw_addr_q.size() - a0, aw_addr_q[a0]);
        end
        tests_run++;
        if (w_data_q.size() - w0 !== 2 || w_data_q[w0+1] !== 32'h4401 || w_last_q[w0+1] !== 1'b1
            || w_last_q[w0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_new_beats got n=%0d last=%h/%b expected n=2 last=00004401/1",
                     w_data_q.size() - w0, w_data_q[w0+1], w_last_q[w0+1]);
        end
        tick();
        tests_run++;
        if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL rstmid_done got %0d expected 1", done_cnt - d0); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_stall();
        test_gaps();
        test_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
